// File: rtl/hvac_actuator_guard.sv
// hvac_actuator_guard: turns controller heat/cool requests into plant enables,
// enforcing a minimum run time, a minimum rest time after every run (and after
// reset), and strict mutual exclusion between heater and cooler.
module hvac_actuator_guard #(
    parameter int unsigned MIN_ON  = 4,
    parameter int unsigned MIN_OFF = 6,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic heating,
    input  logic cooling,
    output logic heater_en,
    output logic cooler_en,
    output logic lockout,
    output logic conflict
);

    typedef enum logic [1:0] {
        REST  = 2'd0,
        READY = 2'd1,
        HEAT  = 2'd2,
        COOL  = 2'd3
    } state_t;

    // Timer values at which the rest period ends / a run may end.
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF - 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             conflict_q;

    // Next-state selection; requests only matter in READY and to end a run.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            REST: begin
                if (timer_q == OFF_LAST) state_d = READY;
            end
            READY: begin
                if (heating && !cooling)      state_d = HEAT;
                else if (cooling && !heating) state_d = COOL;
            end
            HEAT: begin
                if (!heating && (timer_q >= ON_LAST)) state_d = REST;
            end
            COOL: begin
                if (!cooling && (timer_q >= ON_LAST)) state_d = REST;
            end
            default: state_d = REST;
        endcase
    end

    // Dwell timer: restarts on every state change, otherwise saturating count.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q)  timer_d = '0;
        else if (timer_q != '1)  timer_d = timer_q + 1'b1;
    end

    // State, timer and conflict registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= REST;
            timer_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            conflict_q <= heating & cooling;
        end
    end

    assign heater_en = (state_q == HEAT);
    assign cooler_en = (state_q == COOL);
    assign lockout   = (state_q == REST);
    assign conflict  = conflict_q;

endmodule

// File: tb/tb_hvac_actuator_guard.sv
// Self-checking bench for hvac_actuator_guard: directed scenarios with constant
// expectations plus randomized traffic compared against a rest/run model.
module tb_hvac_actuator_guard;

    localparam int MIN_ON  = 4;
    localparam int MIN_OFF = 6;
    localparam int CNT_W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic heating = 1'b0;
    logic cooling = 1'b0;
    logic heater_en, cooler_en, lockout, conflict;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    // Reference model: rest cycles remaining, run direction (+1 heat, -1 cool,
    // 0 idle) and how many cycles the current run has been enabled.
    int m_rest = 0;
    int m_dir  = 0;
    int m_len  = 0;
    bit m_conf = 1'b0;

    hvac_actuator_guard #(.MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .heating(heating), .cooling(cooling),
        .heater_en(heater_en), .cooler_en(cooler_en),
        .lockout(lockout), .conflict(conflict)
    );

    always #5 clk = ~clk;

    // Heater and cooler must never be driven together.
    always @(negedge clk) begin
        if (started) begin
            n_checks++;
            if ((heater_en & cooler_en) !== 1'b0) begin
                n_fail++;
                $display("FAIL mutex: heater_en=%b cooler_en=%b required not both 1", heater_en, cooler_en);
            end
        end
    end

    // Apply inputs for one clock edge, advance the model, settle past the edge.
    task automatic step(input logic h, input logic c, input logic r);
        heating = h; cooling = c; rst = r;
        @(posedge clk);
        if (r) begin
            m_rest = MIN_OFF; m_dir = 0; m_len = 0;
        end else if (m_dir != 0) begin
            if (!((m_dir > 0) ? h : c) && m_len >= MIN_ON) begin
                m_dir = 0; m_rest = MIN_OFF;
            end else begin
                m_len++;
            end
        end else if (m_rest > 0) begin
            m_rest--;
        end else if (h != c) begin
            m_dir = h ? 1 : -1; m_len = 1;
        end
        m_conf = h & c & !r;
        #1;
    endtask

    task automatic wait_ready();
        int i;
        for (i = 0; i < 30; i++) begin
            if (!lockout && !heater_en && !cooler_en) break;
            step(1'b0, 1'b0, 1'b0);
        end
        n_checks++;
        if (i >= 30) begin
            n_fail++;
            $display("FAIL wait_ready: READY not reached within 30 cycles (lockout=%b)", lockout);
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        started = 1'b1;
        n_checks++;
        if ({heater_en, cooler_en, lockout, conflict} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_state: got h/c/lock/conf=%b required 0010", {heater_en, cooler_en, lockout, conflict});
        end
    endtask

    task automatic test_powerup();
        int cyc = 1;
        int lk  = 1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            cyc++;
            if (heater_en) break;
            if (lockout) lk++;
        end
        n_checks++;
        if (lk !== MIN_OFF) begin
            n_fail++; $display("FAIL powerup_lockout: got %0d cycles required %0d", lk, MIN_OFF);
        end
        n_checks++;
        if (cyc !== 8 || heater_en !== 1'b1) begin
            n_fail++; $display("FAIL powerup_heater_rise: got cycle %0d (heater_en=%b) required cycle 8", cyc, heater_en);
        end
    endtask

    task automatic test_short_request();
        int on_cnt = 0;
        int lk = 0;
        wait_ready();
        step(1'b0, 1'b1, 1'b0);
        if (cooler_en) on_cnt++;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (cooler_en) on_cnt++;
            if (lockout) lk++;
        end
        n_checks++;
        if (on_cnt !== MIN_ON) begin
            n_fail++; $display("FAIL short_on_time: got %0d cycles required %0d", on_cnt, MIN_ON);
        end
        n_checks++;
        if (lk !== MIN_OFF) begin
            n_fail++; $display("FAIL short_rest: got %0d cycles required %0d", lk, MIN_OFF);
        end
        n_checks++;
        if (lockout !== 1'b0 || cooler_en !== 1'b0) begin
            n_fail++; $display("FAIL short_ready: got lockout=%b cooler_en=%b required 0 0", lockout, cooler_en);
        end
    endtask

    task automatic test_long_request();
        int on_cnt = 0;
        int lk = 0;
        wait_ready();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (heater_en) on_cnt++;
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (heater_en) on_cnt++;
            if (lockout) lk++;
        end
        n_checks++;
        if (on_cnt !== 10) begin
            n_fail++; $display("FAIL long_on_time: got %0d cycles required 10", on_cnt);
        end
        n_checks++;
        if (lk !== MIN_OFF) begin
            n_fail++; $display("FAIL long_rest: got %0d cycles required %0d", lk, MIN_OFF);
        end
    endtask

    task automatic test_changeover();
        int hc = 0;
        int lk = 0;
        int rdy = 0;
        wait_ready();
        step(1'b1, 1'b0, 1'b0);
        if (heater_en) hc++;
        step(1'b1, 1'b0, 1'b0);
        if (heater_en) hc++;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (cooler_en) break;
            if (heater_en) hc++;
            else if (lockout) lk++;
            else rdy++;
        end
        n_checks++;
        if (hc !== MIN_ON) begin
            n_fail++; $display("FAIL change_heat_time: got %0d cycles required %0d", hc, MIN_ON);
        end
        n_checks++;
        if (lk !== MIN_OFF || rdy !== 1) begin
            n_fail++; $display("FAIL change_gap: got rest=%0d ready=%0d required rest=%0d ready=1", lk, rdy, MIN_OFF);
        end
        n_checks++;
        if (cooler_en !== 1'b1) begin
            n_fail++; $display("FAIL change_cool_on: got cooler_en=%b required 1", cooler_en);
        end
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_conflict();
        wait_ready();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0);
            n_checks++;
            if ({heater_en, cooler_en, lockout, conflict} !== 4'b0001) begin
                n_fail++;
                $display("FAIL conflict_hold%0d: got h/c/lock/conf=%b required 0001", i, {heater_en, cooler_en, lockout, conflict});
            end
        end
        step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({heater_en, cooler_en, lockout, conflict} !== 4'b0100) begin
            n_fail++;
            $display("FAIL conflict_release: got h/c/lock/conf=%b required 0100", {heater_en, cooler_en, lockout, conflict});
        end
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midrun();
        int lk = 1;
        int rdy = 0;
        wait_ready();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if ({cooler_en, lockout} !== 2'b01) begin
            n_fail++; $display("FAIL midrun_drop: got cooler_en/lockout=%b required 01", {cooler_en, lockout});
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (cooler_en) break;
            if (lockout) lk++;
            else rdy++;
        end
        n_checks++;
        if (lk !== MIN_OFF || rdy !== 1 || cooler_en !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_restart: got rest=%0d ready=%0d cooler_en=%b required rest=%0d ready=1 cooler_en=1",
                     lk, rdy, cooler_en, MIN_OFF);
        end
    endtask

    task automatic test_random();
        logic h, c, r;
        int hold;
        int n = 0;
        while (n < 400) begin
            h = ($urandom_range(0, 2) != 0);
            c = ($urandom_range(0, 2) == 0);
            hold = $urandom_range(1, 8);
            for (int k = 0; k < hold; k++) begin
                r = ($urandom_range(0, 59) == 0);
                step(h, c, r);
                n++;
                n_checks++;
                if ({heater_en, cooler_en, lockout, conflict} !==
                    {m_dir == 1, m_dir == -1, (m_dir == 0) && (m_rest > 0), m_conf}) begin
                    n_fail++;
                    $display("FAIL random[%0d]: got h/c/lock/conf=%b required %b", n,
                             {heater_en, cooler_en, lockout, conflict},
                             {m_dir == 1, m_dir == -1, (m_dir == 0) && (m_rest > 0), m_conf});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
        test_short_request();
        test_long_request();
        test_changeover();
        test_conflict();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
